// File: rtl/rv32_barrel_pkg.sv
// Shared widths and the writeback entry type for the barrel register-file write side.
package rv32_barrel_pkg;
  localparam int NUM_HARTS      = 8;
  localparam int HART_CNT_WIDTH = $clog2(NUM_HARTS);
  localparam int XPR_LEN        = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [HART_CNT_WIDTH-1:0] hart;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [XPR_LEN-1:0]        data;
  } wb_entry_t;
endpackage

// File: rtl/rv32_sync_fifo.sv
// Single-clock FIFO with full/empty flags; head data is presented combinationally.
module rv32_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty     = (r_wptr == r_rptr);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign rdata     = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/rv32_barrel_wb_arbiter.sv
// Merges ALU and buffered load writebacks onto the barrel regfile write port,
// tracks one outstanding load per hart and flags load starvation.
module rv32_barrel_wb_arbiter
  import rv32_barrel_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = 4,
  parameter int STARVE_MAX    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  input  logic [HART_CNT_WIDTH-1:0] alu_hart,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [XPR_LEN-1:0]        alu_data,
  input  logic                      ld_issue,
  input  logic [HART_CNT_WIDTH-1:0] ld_issue_hart,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [HART_CNT_WIDTH-1:0] ld_hart,
  input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
  input  logic [XPR_LEN-1:0]        ld_data,
  output logic [HART_CNT_WIDTH-1:0] rd_hart,
  output logic                      wen,
  output logic [REG_ADDR_WIDTH-1:0] wa,
  output logic [XPR_LEN-1:0]        wd,
  output logic [NUM_HARTS-1:0]      ld_pending,
  output logic                      wb_stall,
  output logic                      ld_err
);
  localparam int EW = $bits(wb_entry_t);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [EW-1:0]         w_head_bits;
  wb_entry_t             w_head;
  wb_entry_t             w_ld_entry;
  wb_entry_t             w_wr_entry;
  logic                  w_full, w_empty;
  logic                  w_alu_win, w_pop, w_bypass, w_push;
  logic                  w_retire;
  logic                  w_wen_next;
  logic [NUM_HARTS-1:0]  w_set_mask, w_clr_mask;
  logic                  w_err_next;
  logic [SW-1:0]         w_cnt_next;

  logic [NUM_HARTS-1:0]  r_pending;
  logic [SW-1:0]         r_starve_cnt;
  logic                  r_wen, r_stall, r_err;
  logic [HART_CNT_WIDTH-1:0] r_hart;
  logic [REG_ADDR_WIDTH-1:0] r_wa;
  logic [XPR_LEN-1:0]        r_wd;

  assign w_head     = wb_entry_t'(w_head_bits);
  assign w_ld_entry = '{hart: ld_hart, rd: ld_rd, data: ld_data};

  // Load order holds because a response bypasses only when nothing is queued ahead of it.
  assign w_alu_win = alu_valid && (alu_rd != '0);
  assign w_pop     = !w_alu_win && !w_empty;
  assign w_bypass  = !w_alu_win && w_empty && ld_valid;
  assign ld_ready  = !w_full;
  assign w_push    = ld_valid && ld_ready && !w_bypass;
  assign w_retire  = w_pop || w_bypass;

  always_comb begin
    w_wr_entry = w_ld_entry;
    if (w_alu_win)  w_wr_entry = '{hart: alu_hart, rd: alu_rd, data: alu_data};
    else if (w_pop) w_wr_entry = w_head;
  end

  assign w_wen_next = (w_alu_win || w_retire) && (w_wr_entry.rd != '0);
  assign w_set_mask = ld_issue ? (NUM_HARTS'(1) << ld_issue_hart) : '0;
  assign w_clr_mask = w_retire ? (NUM_HARTS'(1) << w_wr_entry.hart) : '0;

  // Issuing into a hart whose load retires this same cycle is legal back-to-back reuse.
  assign w_err_next = (ld_issue && r_pending[ld_issue_hart] && !w_clr_mask[ld_issue_hart]) ||
                      (w_retire && !r_pending[w_wr_entry.hart]);

  always_comb begin
    w_cnt_next = '0;
    if (!w_empty && !w_pop)
      w_cnt_next = (r_starve_cnt >= SW'(STARVE_MAX)) ? r_starve_cnt : r_starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen        <= 1'b0;
      r_hart       <= '0;
      r_wa         <= '0;
      r_wd         <= '0;
      r_pending    <= '0;
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_wen <= w_wen_next;
      if (w_wen_next) begin
        r_hart <= w_wr_entry.hart;
        r_wa   <= w_wr_entry.rd;
        r_wd   <= w_wr_entry.data;
      end
      r_pending    <= (r_pending & ~w_clr_mask) | w_set_mask;
      r_starve_cnt <= w_cnt_next;
      r_stall      <= (w_cnt_next >= SW'(STARVE_MAX));
      r_err        <= r_err | w_err_next;
    end
  end

  rv32_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (LD_FIFO_DEPTH)
  ) u_ld_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (w_ld_entry),
    .pop   (w_pop),
    .rdata (w_head_bits),
    .full  (w_full),
    .empty (w_empty)
  );

  assign rd_hart    = r_hart;
  assign wen        = r_wen;
  assign wa         = r_wa;
  assign wd         = r_wd;
  assign ld_pending = r_pending;
  assign wb_stall   = r_stall;
  assign ld_err     = r_err;
endmodule

// File: tb/tb_rv32_barrel_wb_arbiter.sv
// Directed bench for the barrel writeback arbiter; write-port traffic is checked against an expected queue.
module tb_rv32_barrel_wb_arbiter;
  import rv32_barrel_pkg::*;

  localparam int EW = HART_CNT_WIDTH + REG_ADDR_WIDTH + XPR_LEN;

  logic                      clk;
  logic                      rst;
  logic                      alu_valid;
  logic [HART_CNT_WIDTH-1:0] alu_hart;
  logic [REG_ADDR_WIDTH-1:0] alu_rd;
  logic [XPR_LEN-1:0]        alu_data;
  logic                      ld_issue;
  logic [HART_CNT_WIDTH-1:0] ld_issue_hart;
  logic                      ld_valid;
  logic                      ld_ready;
  logic [HART_CNT_WIDTH-1:0] ld_hart;
  logic [REG_ADDR_WIDTH-1:0] ld_rd;
  logic [XPR_LEN-1:0]        ld_data;
  logic [HART_CNT_WIDTH-1:0] rd_hart;
  logic                      wen;
  logic [REG_ADDR_WIDTH-1:0] wa;
  logic [XPR_LEN-1:0]        wd;
  logic [NUM_HARTS-1:0]      ld_pending;
  logic                      wb_stall;
  logic                      ld_err;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_got;
  logic [EW-1:0] mon_exp;

  rv32_barrel_wb_arbiter #(.LD_FIFO_DEPTH(4), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_hart(alu_hart), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_hart(ld_issue_hart),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_hart(ld_hart), .ld_rd(ld_rd), .ld_data(ld_data),
    .rd_hart(rd_hart), .wen(wen), .wa(wa), .wd(wd),
    .ld_pending(ld_pending), .wb_stall(wb_stall), .ld_err(ld_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every wen pulse must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && wen) begin
      mon_got = {rd_hart, wa, wd};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got=%h expected=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL wb_order got=%h expected=%h", mon_got, mon_exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_hart = '0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_hart = '0;
    ld_valid = 1'b0; ld_hart = '0; ld_rd = '0; ld_data = '0;
  endtask

  task automatic drive_alu(input int h, input int r, input logic [XPR_LEN-1:0] d);
    alu_valid = 1'b1;
    alu_hart  = HART_CNT_WIDTH'(h);
    alu_rd    = REG_ADDR_WIDTH'(r);
    alu_data  = d;
    if (r != 0) exp_q.push_back({HART_CNT_WIDTH'(h), REG_ADDR_WIDTH'(r), d});
  endtask

  task automatic drive_ld(input int h, input int r, input logic [XPR_LEN-1:0] d);
    ld_valid = 1'b1;
    ld_hart  = HART_CNT_WIDTH'(h);
    ld_rd    = REG_ADDR_WIDTH'(r);
    ld_data  = d;
  endtask

  task automatic issue(input int h);
    ld_issue = 1'b1;
    ld_issue_hart = HART_CNT_WIDTH'(h);
    tick();
    ld_issue = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (wen !== 1'b0 || ld_pending !== '0 || wb_stall !== 1'b0 || ld_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got wen=%b pend=%h stall=%b err=%b expected all 0",
               wen, ld_pending, wb_stall, ld_err);
    end
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ld_ready got=%b expected=1", ld_ready);
    end
  endtask

  task automatic test_alu_write();
    drive_alu(3, 5, 32'hDEADBEEF);
    tick();
    idle();
    checks++;
    if (wen !== 1'b1 || rd_hart !== 3'd3 || wa !== 5'd5 || wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_write got wen=%b hart=%0d wa=%0d wd=%h expected 1/3/5/deadbeef",
               wen, rd_hart, wa, wd);
    end
    tick();
    checks++;
    if (wen !== 1'b0 || wa !== 5'd5 || wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_hold got wen=%b wa=%0d wd=%h expected 0/5/deadbeef", wen, wa, wd);
    end
  endtask

  task automatic test_bypass();
    issue(2);
    checks++;
    if (ld_pending !== 8'h04) begin
      errors++;
      $display("FAIL bypass_pending_set got=%h expected=04", ld_pending);
    end
    drive_ld(2, 7, 32'h1234);
    exp_q.push_back({3'd2, 5'd7, 32'h1234});
    tick();
    idle();
    checks++;
    if (wen !== 1'b1 || wa !== 5'd7 || rd_hart !== 3'd2 || ld_pending !== 8'h00) begin
      errors++;
      $display("FAIL bypass_write got wen=%b wa=%0d hart=%0d pend=%h expected 1/7/2/00",
               wen, wa, rd_hart, ld_pending);
    end
  endtask

  task automatic test_starve();
    logic [EW-1:0] ld_exp[5];
    logic [XPR_LEN-1:0] d;
    for (int h = 0; h < 5; h++) issue(h);
    for (int i = 0; i < 5; i++) begin
      drive_alu(i, i + 1, $urandom());
      d = $urandom();
      drive_ld(i, 10 + i, d);
      ld_exp[i] = {HART_CNT_WIDTH'(i), REG_ADDR_WIDTH'(10 + i), d};
      checks++;
      if (ld_ready !== (i < 4)) begin
        errors++;
        $display("FAIL starve_ld_ready idx=%0d got=%b expected=%b", i, ld_ready, (i < 4));
      end
      tick();
      if (i == 3 || i == 4) begin
        checks++;
        if (wb_stall !== (i == 4)) begin
          errors++;
          $display("FAIL starve_stall idx=%0d got=%b expected=%b", i, wb_stall, (i == 4));
        end
      end
    end
    idle();
    for (int i = 0; i < 4; i++) exp_q.push_back(ld_exp[i]);
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL starve_full_ready got=%b expected=0", ld_ready);
    end
    tick();
    checks++;
    if (wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL starve_release got=%b expected=0", wb_stall);
    end
    repeat (3) tick();
    drive_ld(4, 14, ld_exp[4][XPR_LEN-1:0]);
    exp_q.push_back(ld_exp[4]);
    tick();
    idle();
    tick();
    checks++;
    if (ld_pending !== 8'h00 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL starve_drain got pend=%h left=%0d expected 00/0", ld_pending, exp_q.size());
    end
  endtask

  task automatic test_alu_rd0();
    logic [XPR_LEN-1:0] d;
    issue(1);
    d = $urandom();
    drive_alu(0, 5, $urandom());
    drive_ld(1, 9, d);
    tick();
    idle();
    drive_alu(6, 0, $urandom());
    exp_q.push_back({3'd1, 5'd9, d});
    tick();
    idle();
    checks++;
    if (wen !== 1'b1 || wa !== 5'd9 || rd_hart !== 3'd1 || wd !== d || ld_pending !== 8'h00) begin
      errors++;
      $display("FAIL alu_rd0 got wen=%b wa=%0d hart=%0d wd=%h pend=%h expected 1/9/1/%h/00",
               wen, wa, rd_hart, wd, ld_pending, d);
    end
  endtask

  task automatic test_ld_err();
    checks++;
    if (ld_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean got=%b expected=0", ld_err);
    end
    issue(4);
    issue(4);
    checks++;
    if (ld_err !== 1'b1 || ld_pending !== 8'h10) begin
      errors++;
      $display("FAIL err_double_issue got err=%b pend=%h expected 1/10", ld_err, ld_pending);
    end
    drive_ld(4, 0, $urandom());
    tick();
    idle();
    checks++;
    if (wen !== 1'b0 || ld_pending !== 8'h00) begin
      errors++;
      $display("FAIL err_rd0_discard got wen=%b pend=%h expected 0/00", wen, ld_pending);
    end
    repeat (3) tick();
    checks++;
    if (ld_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got=%b expected=1", ld_err);
    end
  endtask

  task automatic test_mid_reset();
    int wen_seen;
    for (int h = 5; h < 8; h++) issue(h);
    for (int i = 0; i < 3; i++) begin
      drive_alu(i, 20 + i, $urandom());
      drive_ld(5 + i, 1 + i, $urandom());
      tick();
    end
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (wen !== 1'b0 || ld_pending !== '0 || ld_ready !== 1'b1 || ld_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got wen=%b pend=%h ready=%b err=%b expected 0/00/1/0",
               wen, ld_pending, ld_ready, ld_err);
    end
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    wen_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wen === 1'b1) wen_seen++;
    end
    checks++;
    if (wen_seen != 0 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL midreset_empty got wen_pulses=%0d stall=%b expected 0/0", wen_seen, wb_stall);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    test_reset();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    test_alu_write();
    test_bypass();
    test_starve();
    test_alu_rd0();
    test_ld_err();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue got=%0d left expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
